// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and types for the bounded up/down counter.
// Imported by the next-count calculator and the counter top.
package mod_updown_counter_pkg;

    localparam int DEFAULT_BITS      = 8;
    localparam int DEFAULT_STEP_BITS = 4;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_STEP = 2'd2
    } act_e;

endpackage

// File: rtl/mud_next_calc.sv
// Combinational next-count, boundary crossing and load clamp logic.
// Arithmetic is one bit wider than the count so no sum can alias.
module mud_next_calc
    import mod_updown_counter_pkg::*;
#(
    parameter int BITS      = DEFAULT_BITS,
    parameter int STEP_BITS = DEFAULT_STEP_BITS
) (
    input  logic [BITS-1:0]      count,
    input  logic                 enable,
    input  logic                 up,
    input  logic                 down,
    input  logic                 load,
    input  logic [BITS-1:0]      load_value,
    input  logic [BITS-1:0]      limit_lo,
    input  logic [BITS-1:0]      limit_hi,
    input  logic [STEP_BITS-1:0] step,
    input  logic                 mode,
    output logic [BITS-1:0]      next_count,
    output logic                 tc_next,
    output logic                 ovf_set,
    output logic                 unf_set,
    output logic                 cfg_error
);

    localparam int W = BITS + 1;

    logic [W-1:0]    c_w;
    logic [W-1:0]    lo_w;
    logic [W-1:0]    hi_w;
    logic [W-1:0]    step_w;
    logic [W-1:0]    sum_w;
    logic [W-1:0]    lo_step_w;
    logic            up_cross;
    logic            dn_cross;
    logic            count_req;
    logic [BITS-1:0] clamped;
    act_e            act;

    assign c_w       = {1'b0, count};
    assign lo_w      = {1'b0, limit_lo};
    assign hi_w      = {1'b0, limit_hi};
    assign step_w    = W'(step);
    assign sum_w     = c_w + step_w;
    assign lo_step_w = lo_w + step_w;

    assign cfg_error = (limit_lo > limit_hi);

    // An out-of-range count crosses on any step in either direction.
    assign up_cross = (sum_w > hi_w) || (c_w < lo_w);
    assign dn_cross = (c_w < lo_step_w) || (c_w > hi_w);

    assign count_req = enable && (up ^ down) && (step != '0);

    always_comb begin
        clamped = load_value;
        if (load_value < limit_lo) begin
            clamped = limit_lo;
        end else if (load_value > limit_hi) begin
            clamped = limit_hi;
        end
    end

    always_comb begin
        act = ACT_HOLD;
        if (cfg_error) begin
            act = ACT_HOLD;
        end else if (load) begin
            act = ACT_LOAD;
        end else if (count_req) begin
            act = ACT_STEP;
        end
    end

    always_comb begin
        next_count = count;
        tc_next    = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        unique case (act)
            ACT_LOAD: begin
                next_count = clamped;
            end
            ACT_STEP: begin
                if (up) begin
                    if (up_cross) begin
                        ovf_set = 1'b1;
                        if (mode == MODE_SAT) begin
                            next_count = limit_hi;
                            tc_next    = (count != limit_hi);
                        end else begin
                            next_count = limit_lo;
                            tc_next    = 1'b1;
                        end
                    end else begin
                        next_count = BITS'(sum_w);
                    end
                end else begin
                    if (dn_cross) begin
                        unf_set = 1'b1;
                        if (mode == MODE_SAT) begin
                            next_count = limit_lo;
                            tc_next    = (count != limit_lo);
                        end else begin
                            next_count = limit_hi;
                            tc_next    = 1'b1;
                        end
                    end else begin
                        next_count = BITS'(c_w - step_w);
                    end
                end
            end
            ACT_HOLD: begin
                next_count = count;
            end
            default: begin
                next_count = count;
            end
        endcase
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Bounded up/down counter: count, terminal-count pulse and sticky flags.
// All next-state arithmetic lives in mud_next_calc.
module mod_updown_counter
    import mod_updown_counter_pkg::*;
#(
    parameter int BITS      = DEFAULT_BITS,
    parameter int STEP_BITS = DEFAULT_STEP_BITS
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 up,
    input  logic                 down,
    input  logic                 load,
    input  logic [BITS-1:0]      load_value,
    input  logic [BITS-1:0]      limit_lo,
    input  logic [BITS-1:0]      limit_hi,
    input  logic [STEP_BITS-1:0] step,
    input  logic                 mode,
    input  logic                 clear_flags,
    output logic [BITS-1:0]      count,
    output logic                 full_flag,
    output logic                 empty_flag,
    output logic                 tc_pulse,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 cfg_error
);

    logic [BITS-1:0] next_count;
    logic            tc_next;
    logic            ovf_set;
    logic            unf_set;

    mud_next_calc #(
        .BITS      (BITS),
        .STEP_BITS (STEP_BITS)
    ) u_next (
        .count      (count),
        .enable     (enable),
        .up         (up),
        .down       (down),
        .load       (load),
        .load_value (load_value),
        .limit_lo   (limit_lo),
        .limit_hi   (limit_hi),
        .step       (step),
        .mode       (mode),
        .next_count (next_count),
        .tc_next    (tc_next),
        .ovf_set    (ovf_set),
        .unf_set    (unf_set),
        .cfg_error  (cfg_error)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            tc_pulse <= 1'b0;
        end else begin
            count    <= next_count;
            tc_pulse <= tc_next;
        end
    end

    // A set in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow & ~clear_flags);
            underflow <= unf_set | (underflow & ~clear_flags);
        end
    end

    assign full_flag  = (count == limit_hi);
    assign empty_flag = (count == limit_lo);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter with directed vectors.
module tb_mod_updown_counter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       up;
    logic       down;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] limit_lo;
    logic [7:0] limit_hi;
    logic [3:0] step;
    logic       mode;
    logic       clear_flags;
    logic [7:0] count;
    logic       full_flag;
    logic       empty_flag;
    logic       tc_pulse;
    logic       overflow;
    logic       underflow;
    logic       cfg_error;

    logic [7:0] cfg_lo;
    logic [7:0] cfg_hi;
    logic [3:0] cfg_step;
    logic       cfg_mode;

    typedef struct {
        logic [7:0] c;
        logic       tc;
        logic       ov;
        logic       un;
        logic       fu;
        logic       em;
        logic       ce;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    always #5 clock = ~clock;

    mod_updown_counter #(
        .BITS      (8),
        .STEP_BITS (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .up          (up),
        .down        (down),
        .load        (load),
        .load_value  (load_value),
        .limit_lo    (limit_lo),
        .limit_hi    (limit_hi),
        .step        (step),
        .mode        (mode),
        .clear_flags (clear_flags),
        .count       (count),
        .full_flag   (full_flag),
        .empty_flag  (empty_flag),
        .tc_pulse    (tc_pulse),
        .overflow    (overflow),
        .underflow   (underflow),
        .cfg_error   (cfg_error)
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, req);
        end
    endtask

    // Drive one cycle of stimulus and queue the post-edge expectation.
    task automatic cyc(
        input logic en, input logic u, input logic d,
        input logic ld, input logic [7:0] lv, input logic clr,
        input logic [7:0] ec, input logic etc, input logic eov,
        input logic eun, input logic efu, input logic eem,
        input logic ece
    );
        exp_t e;
        @(negedge clock);
        enable      = en;
        up          = u;
        down        = d;
        load        = ld;
        load_value  = lv;
        clear_flags = clr;
        limit_lo    = cfg_lo;
        limit_hi    = cfg_hi;
        step        = cfg_step;
        mode        = cfg_mode;
        step_id++;
        e.c  = ec;
        e.tc = etc;
        e.ov = eov;
        e.un = eun;
        e.fu = efu;
        e.em = eem;
        e.ce = ece;
        e.id = step_id;
        sb.push_back(e);
        @(posedge clock);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({count, tc_pulse, overflow, underflow,
                     full_flag, empty_flag, cfg_error} !==
                    {e.c, e.tc, e.ov, e.un, e.fu, e.em, e.ce}) begin
                    errors++;
                    $display("FAIL step%0d got c=%0d tc=%b ov=%b un=%b fu=%b em=%b ce=%b expected c=%0d tc=%b ov=%b un=%b fu=%b em=%b ce=%b",
                             e.id, count, tc_pulse, overflow, underflow,
                             full_flag, empty_flag, cfg_error,
                             e.c, e.tc, e.ov, e.un, e.fu, e.em, e.ce);
                end
            end
        end
    end

    initial begin : stim
        reset_n     = 1'b0;
        enable      = 1'b0;
        up          = 1'b0;
        down        = 1'b0;
        load        = 1'b0;
        load_value  = 8'd0;
        clear_flags = 1'b0;
        cfg_lo      = 8'd0;
        cfg_hi      = 8'd255;
        cfg_step    = 4'd0;
        cfg_mode    = 1'b0;
        limit_lo    = cfg_lo;
        limit_hi    = cfg_hi;
        step        = cfg_step;
        mode        = cfg_mode;
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_tc", int'(tc_pulse), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_unf", int'(underflow), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // wrap-mode up count across limit_hi
        cfg_lo = 8'd10; cfg_hi = 8'd20; cfg_step = 4'd3; cfg_mode = 1'b0;
        cyc(0, 0, 0, 1, 8'd10, 0, 8'd10, 0, 0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd13, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd16, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd19, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd10, 1, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 8'd0, 0, 8'd10, 0, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 8'd10, 0, 0, 0, 0, 1, 0);

        // saturate-mode down into limit_lo
        cfg_mode = 1'b1; cfg_step = 4'd5;
        cyc(0, 0, 0, 1, 8'd12, 0, 8'd12, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 8'd0, 0, 8'd10, 1, 0, 1, 0, 1, 0);
        cyc(1, 0, 1, 0, 8'd0, 0, 8'd10, 0, 0, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 8'd10, 0, 0, 0, 0, 1, 0);

        // load clamping, load beats counting
        cfg_hi = 8'd200;
        cyc(1, 1, 0, 1, 8'd250, 0, 8'd200, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 8'd5, 0, 8'd10, 0, 0, 0, 0, 1, 0);

        // full range wrap without 8-bit aliasing; set beats clear
        cfg_lo = 8'd0; cfg_hi = 8'd255; cfg_step = 4'd15; cfg_mode = 1'b0;
        cyc(0, 0, 0, 1, 8'd250, 0, 8'd250, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd0, 1, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 8'd250, 0, 8'd250, 0, 1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 8'd0, 1, 8'd0, 1, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 8'd0, 1, 8'd0, 0, 0, 0, 0, 1, 0);

        // hold cases and invalid configuration
        cyc(1, 1, 1, 0, 8'd0, 0, 8'd0, 0, 0, 0, 0, 1, 0);
        cfg_step = 4'd0;
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd0, 0, 0, 0, 0, 1, 0);
        cfg_step = 4'd3;
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd3, 0, 0, 0, 0, 0, 0);
        cfg_lo = 8'd30; cfg_hi = 8'd20;
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd3, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 8'd25, 0, 8'd3, 0, 0, 0, 0, 0, 1);

        // down wrap, saturate at hi, out-of-range count
        cfg_lo = 8'd0; cfg_hi = 8'd255;
        cyc(1, 0, 1, 0, 8'd0, 0, 8'd0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 8'd0, 0, 8'd255, 1, 0, 1, 1, 0, 0);
        cfg_mode = 1'b1;
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd255, 0, 1, 1, 1, 0, 0);
        cfg_lo = 8'd10; cfg_hi = 8'd20;
        cyc(1, 0, 1, 0, 8'd0, 0, 8'd10, 1, 1, 1, 0, 1, 0);

        // asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_tc", int'(tc_pulse), 0);
        chk("async_ovf", int'(overflow), 0);
        chk("async_unf", int'(underflow), 0);
        #1;
        reset_n = 1'b1;
        cfg_lo = 8'd0; cfg_hi = 8'd255; cfg_mode = 1'b0;
        cyc(1, 1, 0, 0, 8'd0, 0, 8'd3, 0, 0, 0, 0, 0, 0);

        @(negedge clock);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clock);
            #2;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter BITS, default 8, count/limit width.
REQ-002 Parameter STEP_BITS, default 4, step width.
REQ-003 clock  input  1  rising-edge clock, single clock domain.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  count qualifier.
REQ-006 up  input  1  count up request.
REQ-007 down  input  1  count down request.
REQ-008 load  input  1  synchronous parallel load.
REQ-009 load_value  input  BITS  value for load.
REQ-010 limit_lo  input  BITS  lower bound, inclusive.
REQ-011 limit_hi  input  BITS  upper bound, inclusive.
REQ-012 step  input  STEP_BITS  increment/decrement magnitude.
REQ-013 mode  input  1  0 = wrap, 1 = saturate.
REQ-014 clear_flags  input  1  clears sticky overflow/underflow.
REQ-015 count  output  BITS  registered count.
REQ-016 full_flag  output  1  count == limit_hi, combinational from registers/limits.
REQ-017 empty_flag  output  1  count == limit_lo, combinational from registers/limits.
REQ-018 tc_pulse  output  1  registered one-cycle pulse on a boundary crossing.
REQ-019 overflow  output  1  sticky, set on an up crossing.
REQ-020 underflow  output  1  sticky, set on a down crossing.
REQ-021 cfg_error  output  1  limit_lo > limit_hi, combinational.

Function
REQ-022 Priority per cycle: cfg_error hold > load > counting > hold.
REQ-023 cfg_error=1: count holds, tc_pulse=0, sticky flags unchanged.
REQ-024 load=1: count <= load_value clamped to [limit_lo, limit_hi]; tc_pulse=0; enable is ignored.
REQ-025 Counting requires enable=1 and exactly one of up/down; up=down=1, up=down=0, or step=0 hold the count with no tc_pulse.
REQ-026 Arithmetic in BITS+1 bits; an up crossing is count+step > limit_hi, a down crossing is count < limit_lo+step; no BITS-bit wrap may occur internally.
REQ-027 No crossing: count <= count ± step, tc_pulse=0.
REQ-028 Up crossing, wrap mode: count <= limit_lo; tc_pulse=1 next cycle; overflow set.
REQ-029 Up crossing, saturate mode: count <= limit_hi; tc_pulse=1 only if count was not already limit_hi; overflow set.
REQ-030 Down crossing mirrors REQ-028/029: wrap mode -> limit_hi, saturate mode -> limit_lo; underflow set.
REQ-031 Count outside limits (limits changed at runtime): any counting step is treated as a crossing in its direction.
REQ-032 clear_flags clears overflow/underflow; a same-cycle set wins over the clear.
REQ-033 Update latency: one clock from the qualifying edge to count/tc_pulse.

Reset
REQ-034 reset_n low asynchronously forces count=0, tc_pulse=0, overflow=0, underflow=0.
REQ-035 Reset asserted mid-operation discards any pending load or step; the first edge after deassertion is evaluated normally.

Structure
REQ-036 Shared package holds the MODE_WRAP/MODE_SAT constants and the default BITS/STEP_BITS.
REQ-037 One sub-module, mud_next_calc: combinational next-count, crossing and clamp logic; the top holds registers and flags.

Verification
REQ-038 All directed tests use BITS=8. Test 1: lo=10, hi=20, step=3, wrap, up from 10 -> 13,16,19,10; tc_pulse high the cycle count shows 10; overflow=1.
REQ-039 Test 2: saturate mode, down from 12, step=5, lo=10 -> 10, then held at 10; a single tc_pulse; underflow=1.
REQ-040 Test 3: load_value=250, lo=10, hi=200 -> count=200, full_flag=1, no tc_pulse.
REQ-041 Test 4: lo=0, hi=255, step=15, up from 250 -> wrap to 0 with no internal 8-bit aliasing; overflow=1.
REQ-042 Test 5: up=down=1 and step=0 each -> count held; lo=30, hi=20 -> cfg_error=1 and count frozen.
REQ-043 Test 6: reset_n pulsed low between clock edges mid-count -> count=0 and flags=0 immediately; clear_flags concurrent with a crossing -> flag stays set.
